// File: rtl/pcm_tdm_pkg.sv
// Shared types and constants for the PCM TDM frame scheduler: FSM states,
// sample/code widths, default framing bytes and the 13-bit to 8-bit segment log encoder.
package pcm_tdm_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, SLOT, DONE} state_t;

  localparam int PCM_LIN_W = 13;
  localparam int PCM_LOG_W = 8;

  localparam logic [PCM_LOG_W-1:0] SYNC_WORD_DEF = 8'hA5;
  localparam logic [PCM_LOG_W-1:0] IDLE_CODE_DEF = 8'hD5;
  localparam logic [PCM_LOG_W-1:0] ALT_INV_MASK  = 8'h55;

  // Sign-magnitude input; the segment is the leading-one position above bit 4.
  function automatic logic [PCM_LOG_W-1:0] pcm_lin2log(input logic [PCM_LIN_W-1:0] x);
    logic [11:0] m;
    logic [2:0]  seg;
    logic [3:0]  man;
    m   = x[11:0];
    seg = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (m[5+k]) seg = 3'(k + 1);
    end
    man = (seg == 3'd0) ? m[4:1] : 4'(m >> seg);
    return {x[12], seg, man};
  endfunction

endpackage

// File: rtl/pcm_byte_serializer.sv
// MSB-first byte serializer: bit timer, shift register, bit counter and bit strobe.
// A load presents data bit 7 on the load cycle itself so consecutive bytes abut.
module pcm_byte_serializer #(
  parameter int BIT_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       ser_data,
  output logic       bit_strobe,
  output logic       byte_done
);

  localparam int TW = $clog2(BIT_DIV);

  logic [TW-1:0] tmr;
  logic [2:0]    bitcnt;
  logic          active;
  logic [7:0]    shreg;
  logic          wrap;

  assign wrap       = active && (tmr == TW'(BIT_DIV - 1));
  assign byte_done  = wrap && (bitcnt == 3'd7);
  assign bit_strobe = load || (active && (tmr == '0));
  assign ser_data   = load ? load_data[7] : shreg[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr    <= '0;
      bitcnt <= '0;
      active <= 1'b0;
    end else if (load) begin
      tmr    <= TW'(1);
      bitcnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (wrap) begin
        tmr <= '0;
        if (bitcnt == 3'd7) active <= 1'b0;
        else                bitcnt <= bitcnt + 1'b1;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end

  // The final wrap does not shift, so the last bit is held through the gap cycle.
  always_ff @(posedge clk) begin
    if (load)                              shreg <= load_data;
    else if (wrap && (bitcnt != 3'd7))     shreg <= {shreg[6:0], 1'b0};
  end

endmodule

// File: rtl/pcm_tdm_frame_scheduler.sv
// TDM frame scheduler: sync byte then one log-encoded byte per channel slot, serialised.
// Define PCM_ALT_BIT_INVERT_EN to XOR every channel code (not the sync byte) with 8'h55.
module pcm_tdm_frame_scheduler
  import pcm_tdm_pkg::*;
#(
  parameter int                     NCH       = 4,
  parameter int                     BIT_DIV   = 16,
  parameter logic [PCM_LOG_W-1:0]   SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [PCM_LOG_W-1:0]   IDLE_CODE = IDLE_CODE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [PCM_LIN_W*NCH-1:0] ch_sample,
  output logic [NCH-1:0]           ch_ready,
  output logic                     ser_data,
  output logic                     bit_strobe,
  output logic                     frame_start,
  output logic                     busy,
  output logic [7:0]               underrun_cnt
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                 state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   ld_p0, ld_n;
  logic                   slot_ld;
  logic [PCM_LIN_W-1:0]   smp;
  logic [PCM_LOG_W-1:0]   enc_code, slot_code, load_data;
  logic                   ser_bit, byte_done;

  assign slot_ld     = ld_p0 && (state == SLOT);
  assign frame_start = ld_p0 && (state == SYNC);
  assign busy        = (state != IDLE);
  assign ser_data    = (state == IDLE) ? 1'b1 : ser_bit;

  assign smp      = ch_sample[PCM_LIN_W*idx +: PCM_LIN_W];
  assign enc_code = pcm_lin2log(smp);

`ifdef PCM_ALT_BIT_INVERT_EN
  assign slot_code = (ch_valid[idx] ? enc_code : IDLE_CODE) ^ ALT_INV_MASK;
`else
  assign slot_code = ch_valid[idx] ? enc_code : IDLE_CODE;
`endif

  assign load_data = (state == SYNC) ? SYNC_WORD : slot_code;

  always_comb begin
    ch_ready = '0;
    if (slot_ld && ch_valid[idx]) ch_ready[idx] = 1'b1;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    ld_n    = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_n = SYNC;
        ld_n    = 1'b1;
      end
      SYNC: if (byte_done) begin
        state_n = SLOT;
        idx_n   = '0;
        ld_n    = 1'b1;
      end
      SLOT: if (byte_done) begin
        if (idx == IW'(NCH - 1)) begin
          state_n = DONE;
        end else begin
          idx_n = idx + 1'b1;
          ld_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = enable ? SYNC : IDLE;
        ld_n    = enable;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      ld_p0        <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ld_p0 <= ld_n;
      if (slot_ld && !ch_valid[idx] && (underrun_cnt != 8'hFF))
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

  pcm_byte_serializer #(
    .BIT_DIV(BIT_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ld_p0),
    .load_data (load_data),
    .ser_data  (ser_bit),
    .bit_strobe(bit_strobe),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_pcm_tdm_frame_scheduler.sv
// Bench for pcm_tdm_frame_scheduler: captures serial frames and compares against a
// behavioural model of the frame format, slot handshake and underrun counter.
module tb_pcm_tdm_frame_scheduler;

  localparam int NCH  = 4;
  localparam int BD   = 4;
  localparam int NB   = NCH + 1;
  localparam int FLEN = NB * 8 * BD + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [NCH-1:0]    ch_valid = '0;
  logic [13*NCH-1:0] ch_sample = '0;
  logic [NCH-1:0]    ch_ready;
  logic              ser_data, bit_strobe, frame_start, busy;
  logic [7:0]        underrun_cnt;

  int total = 0;
  int bad   = 0;
  int model_under = 0;

  logic [7:0] cap_bytes [0:NB-1];
  logic [7:0] exp_bytes [0:NB-1];
  int         cap_rdy   [0:NCH-1];
  int         cap_len;
  int         cap_err;

  always #5 clk = ~clk;

  pcm_tdm_frame_scheduler #(.NCH(NCH), .BIT_DIV(BD)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_valid(ch_valid), .ch_sample(ch_sample),
    .ch_ready(ch_ready), .ser_data(ser_data), .bit_strobe(bit_strobe),
    .frame_start(frame_start), .busy(busy), .underrun_cnt(underrun_cnt)
  );

  function automatic logic [7:0] model_code(input logic v, input logic [12:0] s);
    int m, seg, man;
    logic [7:0] c;
    if (!v) c = 8'hD5;
    else begin
      m = int'(s[11:0]);
      seg = 0;
      for (int e = 1; e <= 7; e++) if (m >= (1 << (e + 4))) seg = e;
      man = (m >> ((seg < 2) ? 1 : seg)) % 16;
      c = {s[12], 3'(seg), 4'(man)};
    end
`ifdef PCM_ALT_BIT_INVERT_EN
    c = c ^ 8'h55;
`endif
    return c;
  endfunction

  task automatic build_expected();
    exp_bytes[0] = 8'hA5;
    for (int i = 0; i < NCH; i++)
      exp_bytes[i+1] = model_code(ch_valid[i], ch_sample[13*i +: 13]);
  endtask

  task automatic model_frame_done();
    for (int i = 0; i < NCH; i++)
      if (!ch_valid[i] && model_under < 255) model_under++;
  endtask

  task automatic randomize_inputs(input bit rand_valid);
    logic [11:0] mag;
    for (int i = 0; i < NCH; i++) begin
      mag = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
      ch_sample[13*i +: 13] = {1'($urandom), mag};
    end
    ch_valid = rand_valid ? NCH'($urandom) : '1;
  endtask

  // Called at a negedge; returns at the negedge where busy falls or the next frame starts.
  task automatic capture(input int drop_off);
    int w, cyc, k, j;
    bit exp_strobe;
    w = 0;
    while (frame_start !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    cap_err = 0;
    cap_len = -1;
    for (int i = 0; i < NCH; i++) cap_rdy[i] = 0;
    if (w >= 2000) begin
      total++; bad++;
      $display("FAIL frame_start_timeout: waited %0d cycles, required a frame_start", w);
      return;
    end
    cyc = 0;
    while (1) begin
      if (cyc == drop_off) enable = 1'b0;
      k = cyc / BD;
      j = cyc % BD;
      exp_strobe = (k < NB * 8) && (j == 0);
      if (bit_strobe !== exp_strobe) cap_err++;
      if (k < NB * 8) begin
        if (j == 0) cap_bytes[k/8][7-(k%8)] = ser_data;
        else if (ser_data !== cap_bytes[k/8][7-(k%8)]) cap_err++;
      end else if (ser_data !== cap_bytes[NB-1][0]) cap_err++;
      if ($countones(ch_ready) > 1) cap_err++;
      for (int i = 0; i < NCH; i++)
        if (ch_ready[i] === 1'b1) begin
          if (cyc == (i + 1) * 8 * BD) cap_rdy[i]++;
          else cap_err++;
        end
      @(negedge clk);
      cyc++;
      if (frame_start === 1'b1 || busy !== 1'b1 || cyc > 3000) break;
    end
    cap_len = cyc;
  endtask

  task automatic check_frame_common(input string tag);
    total++;
    if (cap_len !== FLEN) begin
      bad++; $display("FAIL %s_len: got %0d required %0d", tag, cap_len, FLEN);
    end
    total++;
    if (cap_err !== 0) begin
      bad++; $display("FAIL %s_timing: got %0d strobe/serial/ready errors required 0", tag, cap_err);
    end
    for (int b = 0; b < NB; b++) begin
      total++;
      if (cap_bytes[b] !== exp_bytes[b]) begin
        bad++; $display("FAIL %s_byte%0d: got %h required %h", tag, b, cap_bytes[b], exp_bytes[b]);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (cap_rdy[i] !== int'(ch_valid[i])) begin
        bad++; $display("FAIL %s_ready%0d: got %0d pulses required %0d", tag, i, cap_rdy[i], int'(ch_valid[i]));
      end
    end
    total++;
    if (underrun_cnt !== 8'(model_under)) begin
      bad++; $display("FAIL %s_underrun: got %0d required %0d", tag, underrun_cnt, model_under);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({ser_data, busy, frame_start, bit_strobe, ch_ready, underrun_cnt} !== {1'b1, 3'b000, {NCH{1'b0}}, 8'h00}) begin
      bad++; $display("FAIL reset_outputs: got ser=%b busy=%b fs=%b bs=%b rdy=%b ur=%0d required ser=1 others 0",
                      ser_data, busy, frame_start, bit_strobe, ch_ready, underrun_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ser_data !== 1'b1) begin
      bad++; $display("FAIL idle_hold: got busy=%b ser=%b required busy=0 ser=1", busy, ser_data);
    end
  endtask

  task automatic test_vector();
    logic [7:0] lit [0:NB-1];
`ifdef PCM_ALT_BIT_INVERT_EN
    lit = '{8'hA5, 8'h55, 8'h2A, 8'hF5, 8'h45};
`else
    lit = '{8'hA5, 8'h00, 8'h7F, 8'hA0, 8'h10};
`endif
    ch_sample = {13'h0021, 13'h1040, 13'h0FFF, 13'h0000};
    ch_valid  = '1;
    build_expected();
    for (int b = 0; b < NB; b++) exp_bytes[b] = lit[b];
    enable = 1'b1;
    capture(1);
    model_frame_done();
    check_frame_common("vector");
  endtask

  task automatic test_underrun();
    randomize_inputs(1'b0);
    ch_valid = 4'b1011;
    build_expected();
    total++;
`ifdef PCM_ALT_BIT_INVERT_EN
    if (exp_bytes[3] !== 8'h80) begin
      bad++; $display("FAIL underrun_model: got %h required 80", exp_bytes[3]);
    end
`else
    if (exp_bytes[3] !== 8'hD5) begin
      bad++; $display("FAIL underrun_model: got %h required d5", exp_bytes[3]);
    end
`endif
    enable = 1'b1;
    capture(1);
    model_frame_done();
    check_frame_common("underrun");
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      randomize_inputs(1'b1);
      build_expected();
      enable = 1'b1;
      capture(1);
      model_frame_done();
      check_frame_common($sformatf("rand%0d", f));
    end
  endtask

  task automatic test_back_to_back();
    randomize_inputs(1'b1);
    build_expected();
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture((f == 2) ? 1 : -1);
      model_frame_done();
      check_frame_common($sformatf("b2b%0d", f));
    end
  endtask

  task automatic test_enable_drop();
    randomize_inputs(1'b1);
    build_expected();
    enable = 1'b1;
    capture(2 * 8 * BD + 5);
    model_frame_done();
    check_frame_common("endrop");
    repeat (10) begin
      total++;
      if (busy !== 1'b0 || ser_data !== 1'b1 || frame_start !== 1'b0) begin
        bad++; $display("FAIL endrop_idle: got busy=%b ser=%b fs=%b required 0 1 0", busy, ser_data, frame_start);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    int w;
    randomize_inputs(1'b0);
    ch_valid = 4'b1110;
    enable = 1'b1;
    w = 0;
    while (frame_start !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    repeat (2 * 8 * BD + 6) @(negedge clk);
    total++;
    if (underrun_cnt !== 8'((model_under < 255) ? model_under + 1 : 255) || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: got ur=%0d busy=%b required ur=%0d busy=1", underrun_cnt, busy,
                      (model_under < 255) ? model_under + 1 : 255);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ser_data, busy, ch_ready, underrun_cnt} !== {1'b1, 1'b0, {NCH{1'b0}}, 8'h00}) begin
      bad++; $display("FAIL rstmid_abort: got ser=%b busy=%b rdy=%b ur=%0d required 1 0 0 0",
                      ser_data, busy, ch_ready, underrun_cnt);
    end
    model_under = 0;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ch_valid = '1;
    build_expected();
    enable = 1'b1;
    capture(1);
    model_frame_done();
    check_frame_common("rstmid_restart");
  endtask

  task automatic test_saturation();
    ch_valid = '0;
    build_expected();
    enable = 1'b1;
    for (int f = 0; f < 65; f++) begin
      capture((f == 64) ? 1 : -1);
      model_frame_done();
    end
    check_frame_common("saturate");
    total++;
    if (underrun_cnt !== 8'd255) begin
      bad++; $display("FAIL saturate_cap: got %0d required 255", underrun_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_underrun();
    test_random();
    test_back_to_back();
    test_enable_drop();
    test_rst_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
